command_issue_unit: RTL and testbench
=====================================

Name: command_issue_unit

Overview:
- Front end of the 16-bit core; drives the command stream into the decode stage.
- Fetches 16-bit words from a synchronous instruction memory with 1-cycle read latency.
- Maintains the 3-deep command history (current, one-before, two-before) that the decoder's forwarding logic consumes.
- Inserts bubbles on stall/flush and freezes on HALT.

Parameters:
ADDR_W, 12, instruction memory address width; PC wraps modulo 2^ADDR_W
BUBBLE_CMD, 16'hC0E0, bubble encoding (ALU class, op field 1110: no register write, no memory access, no PC load)
RESET_PC, 0, first fetch address after reset

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  synchronous, active-high
imem_addr  out  ADDR_W  instruction memory read address
imem_rdata  in  16  word for the address presented on the previous cycle
stall  in  1  hold the entire issue stage (downstream not ready)
flush  in  1  taken branch resolved in execute; redirect fetch
branch_target  in  ADDR_W  redirect address, sampled when flush=1
cmd  out  16  COMMAND to decoder
cmd_before  out  16  BeforeCOMMAND
cmd_two_before  out  16  TwoBeforeCOMMAND
cmd_valid  out  1  cmd is a real fetched instruction (not a bubble)
cmd_pc  out  ADDR_W  address of cmd
halted  out  1  HALT has been issued

Behaviour:
- Clock/reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset values:
  - cmd, cmd_before, cmd_two_before = BUBBLE_CMD
  - cmd_valid = 0, cmd_pc = 0, halted = 0
  - fetch_pc = RESET_PC, state = FILL
- Internal registers:
  - fetch_pc: next address to request.
  - pend_pc: address of the word currently on imem_rdata.
- imem_addr = stall ? pend_pc : fetch_pc. Re-presenting pend_pc keeps imem_rdata stable across any stall length.
- States:
  - FILL: first cycle after reset. Issue fetch_pc, issue a bubble, fetch_pc += 1 -> RUN.
  - RUN, no stall: cmd <= imem_rdata, cmd_pc <= pend_pc, cmd_valid <= 1, fetch_pc += 1. The history shifts in the same edge: cmd_two_before <= cmd_before, cmd_before <= cmd.
  - RUN, stall=1: all outputs and registers hold, including the history.
  - flush=1 (any state except HALT; priority over stall): cmd <= BUBBLE_CMD, cmd_valid <= 0, history shifts, fetch_pc <= branch_target -> REFILL.
  - REFILL: imem_rdata is stale and is discarded. Issue a second bubble (shift), fetch_pc += 1 -> RUN. Taken-branch penalty is therefore exactly 2 bubbles.
  - HALT detection: a word with [15:14]=11 and [7:4]=1111 is issued as cmd normally, halted <= 1 -> HALT.
    - flush asserted in that same cycle wins: no HALT, because the HALT was speculative.
  - HALT: every cycle issue a bubble with the history shifting, so older ops drain out of the history. fetch_pc and imem_addr freeze; stall and flush are ignored. Exit only via reset.
- Boundaries:
  - fetch_pc wraps 2^ADDR_W-1 -> 0 with no flag.
  - branch_target equal to the current pend_pc is legal.
  - stall and flush together: flush wins.
  - Reset asserted mid-stall or mid-REFILL returns to the FILL/reset values on the next edge.
- Latency: a word appears on cmd 2 cycles after its address is first presented (no stall).

Optional Feature:
CMD_ISSUE_PERF_EN
- Defined: adds output ports issued_count[15:0] and bubble_count[15:0].
  - Both are saturating counters, cleared by reset.
  - issued_count increments on each edge where cmd_valid goes/stays 1 with a new word.
  - bubble_count increments on each bubble-issue edge (FILL, flush, REFILL, HALT).
  - Neither counter changes while stalled.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package simple_isa_pkg:
  - BUBBLE_CMD default
  - HALT match fields (class 2'b11, op 4'b1111)
  - issue-state enum {FILL, RUN, REFILL, HALT}
- Sub-module cmd_history_shift: 3-entry 16-bit shift register with hold (stall) and bubble-insert inputs, reset to BUBBLE_CMD.

Test Plan:
- Memory words 0..3 = 16'h0801, 16'hC160, 16'hC240, 16'h4A03, no stall. Required:
  - cmd = 16'h0801 in cycle 2, then one new word per cycle.
  - In cycle 5: cmd_before = 16'hC240, cmd_two_before = 16'hC160.
  - cmd_pc follows 0, 1, 2, 3.
- stall held 3 cycles while cmd=16'hC160. Required: cmd, history and cmd_pc stay constant; imem_addr = pend_pc; after release, next cmd = word 2 with no word lost or duplicated.
- flush with branch_target=12'h040 while cmd_pc=5. Required: next 2 cycles cmd = 16'hC0E0 with cmd_valid=0, then cmd = mem[0x040], cmd_pc = 12'h040.
- HALT word 16'hC0F0 at addr 6. Required: halted=1 after issue; subsequent cmd = 16'hC0E0; imem_addr frozen; flush is ignored.
- HALT issued in the same cycle as flush to 12'h010. Required: halted stays 0; redirect occurs.
- fetch_pc at 12'hFFF. Required: next imem_addr = 12'h000; reset asserted during REFILL gives reset values on the next edge.

Source files
------------

// File: rtl/simple_isa_pkg.sv
// Shared encodings for the 16-bit core front end: bubble word, HALT match fields, issue states.
package simple_isa_pkg;

  localparam logic [15:0] BUBBLE_CMD_DEF = 16'hC0E0;
  localparam logic [1:0]  HALT_CLASS     = 2'b11;
  localparam logic [3:0]  HALT_OP        = 4'b1111;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    REFILL,
    HALT
  } issue_state_e;

  function automatic logic is_halt(input logic [15:0] word);
    return (word[15:14] == HALT_CLASS) && (word[7:4] == HALT_OP);
  endfunction

endpackage

// File: rtl/cmd_history_shift.sv
// Three-deep command history (current, one-before, two-before) with hold and bubble insert.
module cmd_history_shift
  import simple_isa_pkg::*;
#(
  parameter logic [15:0] BUBBLE_CMD = BUBBLE_CMD_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hold,
  input  logic        insert_bubble,
  input  logic [15:0] new_word,
  output logic [15:0] cmd,
  output logic [15:0] cmd_before,
  output logic [15:0] cmd_two_before
);

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd            <= BUBBLE_CMD;
      cmd_before     <= BUBBLE_CMD;
      cmd_two_before <= BUBBLE_CMD;
    end else if (!hold) begin
      cmd_two_before <= cmd_before;
      cmd_before     <= cmd;
      cmd            <= insert_bubble ? BUBBLE_CMD : new_word;
    end
  end

endmodule

// File: rtl/command_issue_unit.sv
// Fetch/issue front end feeding the decoder; inserts bubbles on flush and freezes on HALT.
// Optional perf counters (issued_count, bubble_count) are built when CMD_ISSUE_PERF_EN is defined.
module command_issue_unit
  import simple_isa_pkg::*;
#(
  parameter int unsigned          ADDR_W     = 12,
  parameter logic [15:0]          BUBBLE_CMD = BUBBLE_CMD_DEF,
  parameter logic [ADDR_W-1:0]    RESET_PC   = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [15:0]       cmd,
  output logic [15:0]       cmd_before,
  output logic [15:0]       cmd_two_before,
  output logic              cmd_valid,
  output logic [ADDR_W-1:0] cmd_pc,
  output logic              halted
`ifdef CMD_ISSUE_PERF_EN
  ,
  output logic [15:0]       issued_count,
  output logic [15:0]       bubble_count
`endif
);

  issue_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pend_pc_q;
  logic              cmd_valid_d;
  logic [ADDR_W-1:0] cmd_pc_d;
  logic              halted_d;
  logic              hist_hold_c;
  logic              hist_bubble_c;
  logic              issue_word_c;
  logic              issue_bubble_c;

  // Re-presenting pend_pc during a stall keeps imem_rdata stable; HALT ignores stall.
  assign imem_addr = (stall && (state_q != HALT)) ? pend_pc_q : fetch_pc_q;

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    cmd_valid_d    = cmd_valid;
    cmd_pc_d       = cmd_pc;
    halted_d       = halted;
    hist_hold_c    = 1'b1;
    hist_bubble_c  = 1'b1;
    issue_word_c   = 1'b0;
    issue_bubble_c = 1'b0;

    if (state_q == HALT) begin
      hist_hold_c    = 1'b0;
      cmd_valid_d    = 1'b0;
      issue_bubble_c = 1'b1;
    end else if (flush) begin
      hist_hold_c    = 1'b0;
      cmd_valid_d    = 1'b0;
      fetch_pc_d     = branch_target;
      state_d        = REFILL;
      issue_bubble_c = 1'b1;
    end else if (!stall) begin
      hist_hold_c = 1'b0;
      fetch_pc_d  = fetch_pc_q + ADDR_W'(1);
      state_d     = RUN;
      if (state_q == RUN) begin
        hist_bubble_c = 1'b0;
        cmd_valid_d   = 1'b1;
        cmd_pc_d      = pend_pc_q;
        issue_word_c  = 1'b1;
        if (is_halt(imem_rdata)) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end
      end else begin
        // FILL and REFILL: data on imem_rdata is not for a requested address yet.
        cmd_valid_d    = 1'b0;
        issue_bubble_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FILL;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      cmd_valid  <= 1'b0;
      cmd_pc     <= '0;
      halted     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= imem_addr;
      cmd_valid  <= cmd_valid_d;
      cmd_pc     <= cmd_pc_d;
      halted     <= halted_d;
    end
  end

  cmd_history_shift #(
    .BUBBLE_CMD(BUBBLE_CMD)
  ) u_history (
    .clock         (clock),
    .reset         (reset),
    .hold          (hist_hold_c),
    .insert_bubble (hist_bubble_c),
    .new_word      (imem_rdata),
    .cmd           (cmd),
    .cmd_before    (cmd_before),
    .cmd_two_before(cmd_two_before)
  );

`ifdef CMD_ISSUE_PERF_EN
  // Saturating event counters; stalled cycles raise neither issue strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      issued_count <= '0;
      bubble_count <= '0;
    end else begin
      if (issue_word_c && (issued_count != 16'hFFFF)) issued_count <= issued_count + 16'd1;
      if (issue_bubble_c && (bubble_count != 16'hFFFF)) bubble_count <= bubble_count + 16'd1;
    end
  end
`else
  logic perf_unused_c;
  assign perf_unused_c = issue_word_c ^ issue_bubble_c;
`endif

endmodule

// File: tb/tb_command_issue_unit.sv
// Directed bench for command_issue_unit: fill, stall, flush, HALT, HALT-vs-flush, PC wrap, reset in REFILL.
module tb_command_issue_unit;

  logic        clock;
  logic        reset;
  logic [11:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [11:0] branch_target;
  logic [15:0] cmd;
  logic [15:0] cmd_before;
  logic [15:0] cmd_two_before;
  logic        cmd_valid;
  logic [11:0] cmd_pc;
  logic        halted;
`ifdef CMD_ISSUE_PERF_EN
  logic [15:0] issued_count;
  logic [15:0] bubble_count;
`endif

  logic [15:0] mem [0:4095];
  int checks = 0;
  int errors = 0;

  command_issue_unit dut (
    .clock         (clock),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .cmd           (cmd),
    .cmd_before    (cmd_before),
    .cmd_two_before(cmd_two_before),
    .cmd_valid     (cmd_valid),
    .cmd_pc        (cmd_pc),
    .halted        (halted)
`ifdef CMD_ISSUE_PERF_EN
    ,
    .issued_count  (issued_count),
    .bubble_count  (bubble_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous instruction memory, one cycle read latency
  always @(posedge clock) imem_rdata <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cmd(input string tag, input logic [15:0] c, input logic v, input logic [11:0] pc);
    chk({tag, "_cmd"}, 32'(cmd), 32'(c));
    chk({tag, "_valid"}, 32'(cmd_valid), 32'(v));
    chk({tag, "_pc"}, 32'(cmd_pc), 32'(pc));
  endtask

  task automatic expect_reset_vals(input string tag);
    chk({tag, "_cmd"}, 32'(cmd), 32'h0000C0E0);
    chk({tag, "_before"}, 32'(cmd_before), 32'h0000C0E0);
    chk({tag, "_two_before"}, 32'(cmd_two_before), 32'h0000C0E0);
    chk({tag, "_valid"}, 32'(cmd_valid), 32'h0);
    chk({tag, "_pc"}, 32'(cmd_pc), 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'h0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Returns at the negedge of cycle 0 (FILL) with reset released
  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    branch_target = 12'h000;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[0]     = 16'h0801;
    mem[1]     = 16'hC160;
    mem[2]     = 16'hC240;
    mem[3]     = 16'h4A03;
    mem[4]     = 16'h1004;
    mem[5]     = 16'h2005;
    mem[6]     = 16'hC0F0;
    mem[7]     = 16'h3007;
    mem[8]     = 16'h3008;
    mem[12'h010] = 16'h5510;
    mem[12'h011] = 16'h5611;
    mem[12'h040] = 16'h3A40;
    mem[12'h041] = 16'h3B41;
    mem[12'hFFE] = 16'h1FFE;
    mem[12'hFFF] = 16'h1FFF;
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    branch_target = 12'h000;

    // Straight-line fill and history
    do_reset();
    expect_reset_vals("rst");
    cyc(1);
    expect_cmd("a_c1", 16'hC0E0, 1'b0, 12'h000);
    chk("a_c1_addr", 32'(imem_addr), 32'h1);
    cyc(1); expect_cmd("a_c2", 16'h0801, 1'b1, 12'h000);
    cyc(1); expect_cmd("a_c3", 16'hC160, 1'b1, 12'h001);
    cyc(1); expect_cmd("a_c4", 16'hC240, 1'b1, 12'h002);
    cyc(1); expect_cmd("a_c5", 16'h4A03, 1'b1, 12'h003);
    chk("a_c5_before", 32'(cmd_before), 32'h0000C240);
    chk("a_c5_two_before", 32'(cmd_two_before), 32'h0000C160);

    // Three-cycle stall while C160 is current
    do_reset();
    cyc(3);
    expect_cmd("b_c3", 16'hC160, 1'b1, 12'h001);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      expect_cmd("b_hold", 16'hC160, 1'b1, 12'h001);
      chk("b_hold_before", 32'(cmd_before), 32'h00000801);
      chk("b_hold_two_before", 32'(cmd_two_before), 32'h0000C0E0);
      chk("b_hold_addr", 32'(imem_addr), 32'h2);
    end
    stall = 1'b0;
    cyc(1);
    expect_cmd("b_c7", 16'hC240, 1'b1, 12'h002);
    chk("b_c7_before", 32'(cmd_before), 32'h0000C160);
    cyc(1);
    expect_cmd("b_c8", 16'h4A03, 1'b1, 12'h003);

    // Flush to 0x040 while cmd_pc = 5 (HALT word on rdata is speculative)
    do_reset();
    cyc(7);
    expect_cmd("c_c7", 16'h2005, 1'b1, 12'h005);
    flush = 1'b1;
    branch_target = 12'h040;
    cyc(1);
    flush = 1'b0;
    chk("c_c8_cmd", 32'(cmd), 32'h0000C0E0);
    chk("c_c8_valid", 32'(cmd_valid), 32'h0);
    chk("c_c8_halted", 32'(halted), 32'h0);
    chk("c_c8_addr", 32'(imem_addr), 32'h040);
    cyc(1);
    chk("c_c9_cmd", 32'(cmd), 32'h0000C0E0);
    chk("c_c9_valid", 32'(cmd_valid), 32'h0);
    cyc(1);
    expect_cmd("c_c10", 16'h3A40, 1'b1, 12'h040);
    chk("c_c10_before", 32'(cmd_before), 32'h0000C0E0);
    chk("c_c10_two_before", 32'(cmd_two_before), 32'h0000C0E0);
    cyc(1);
    expect_cmd("c_c11", 16'h3B41, 1'b1, 12'h041);

    // HALT at address 6; stall and flush ignored afterwards
    do_reset();
    cyc(7);
    chk("d_c7_halted", 32'(halted), 32'h0);
    cyc(1);
    expect_cmd("d_c8", 16'hC0F0, 1'b1, 12'h006);
    chk("d_c8_halted", 32'(halted), 32'h1);
    chk("d_c8_addr", 32'(imem_addr), 32'h8);
    flush = 1'b1;
    stall = 1'b1;
    branch_target = 12'h123;
    #1;
    chk("d_c8_addr_stall", 32'(imem_addr), 32'h8);
    cyc(1);
    chk("d_c9_cmd", 32'(cmd), 32'h0000C0E0);
    chk("d_c9_valid", 32'(cmd_valid), 32'h0);
    chk("d_c9_before", 32'(cmd_before), 32'h0000C0F0);
    chk("d_c9_halted", 32'(halted), 32'h1);
    chk("d_c9_addr", 32'(imem_addr), 32'h8);
    cyc(1);
    chk("d_c10_cmd", 32'(cmd), 32'h0000C0E0);
    chk("d_c10_two_before", 32'(cmd_two_before), 32'h0000C0F0);
    chk("d_c10_addr", 32'(imem_addr), 32'h8);
    chk("d_c10_halted", 32'(halted), 32'h1);
    flush = 1'b0;
    stall = 1'b0;

    // HALT word on rdata in the same cycle as flush to 0x010
    do_reset();
    cyc(7);
    flush = 1'b1;
    branch_target = 12'h010;
    cyc(1);
    flush = 1'b0;
    chk("e_c8_halted", 32'(halted), 32'h0);
    chk("e_c8_addr", 32'(imem_addr), 32'h010);
    cyc(2);
    expect_cmd("e_c10", 16'h5510, 1'b1, 12'h010);
    chk("e_c10_halted", 32'(halted), 32'h0);

    // PC wrap at 0xFFF, then reset during REFILL
    do_reset();
    cyc(2);
    expect_cmd("f_c2", 16'h0801, 1'b1, 12'h000);
    flush = 1'b1;
    branch_target = 12'hFFE;
    cyc(1);
    flush = 1'b0;
    chk("f_c3_addr", 32'(imem_addr), 32'hFFE);
    cyc(1);
    chk("f_c4_addr", 32'(imem_addr), 32'hFFF);
    cyc(1);
    chk("f_c5_addr", 32'(imem_addr), 32'h000);
    expect_cmd("f_c5", 16'h1FFE, 1'b1, 12'hFFE);
    cyc(1); expect_cmd("f_c6", 16'h1FFF, 1'b1, 12'hFFF);
    cyc(1); expect_cmd("f_c7", 16'h0801, 1'b1, 12'h000);
    flush = 1'b1;
    branch_target = 12'h040;
    cyc(1);
    flush = 1'b0;
    chk("f_c8_valid", 32'(cmd_valid), 32'h0);
    reset = 1'b1;
    cyc(1);
    expect_reset_vals("f_rst");
    reset = 1'b0;
    cyc(2);
    expect_cmd("f_after_rst", 16'h0801, 1'b1, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
